ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard over the same two open-drain lines the PS/2 receive path samples.
- Implements the host request sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop, device ACK.
- Exposes a valid/ready command port and a busy flag. The receive path uses the busy flag to ignore bus activity generated by its own transmission.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles ps2 clock is held low before the start bit (100 us at 50 MHz); minimum 2.
- TIMEOUT_CYCLES, 750000, maximum clk cycles from clock release to ACK seen (15 ms at 50 MHz).
- CNT_W, 20, width of the shared cycle counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- tx_data  input  8  command byte, sampled on accept.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  high only in IDLE; accept = tx_valid && tx_ready at posedge clk.
- tx_busy  output  1  equals !tx_ready.
- tx_done  output  1  one-cycle pulse: byte sent and ACK received.
- tx_error  output  1  one-cycle pulse: timeout or missing ACK.
- ps2_clk_in  input  1  raw ps2 clock pad level (asynchronous).
- ps2_data_in  input  1  raw ps2 data pad level (asynchronous).
- ps2_clk_oe  output  1  1 = drive ps2 clock low; 0 = release (pulled up).
- ps2_data_oe  output  1  1 = drive ps2 data low; 0 = release.

Behaviour:
- Input conditioning: both pad inputs pass through a 2-flop synchronizer. A falling edge (fall) is detected when the registered previous synced clock = 1 and the current synced clock = 0, so it is seen 3 clk after the pad edge.
- Reset (async, while reset_n = 0): state = IDLE, tx_ready = 1, tx_busy = 0, tx_done = 0, tx_error = 0, ps2_clk_oe = 0, ps2_data_oe = 0, counters = 0. Applied mid-transfer it releases both lines immediately and sends no pulse.
- All outputs are registered.
- FSM states: IDLE, INHIBIT, SEND, ACK, WAIT_IDLE.
- IDLE:
  - Both oe = 0.
  - On accept, load the 10-bit frame {1'b1 stop, ~^tx_data parity, tx_data}, clear the counter, go to INHIBIT.
  - tx_valid when not ready is ignored and not queued.
- INHIBIT:
  - ps2_clk_oe = 1, ps2_data_oe = 0 for INHIBIT_CYCLES-1 cycles.
  - On the last cycle, ps2_data_oe rises to 1 (start bit).
  - Next cycle: ps2_clk_oe = 0, ps2_data_oe stays 1, counter clears, go to SEND with bit_cnt = 0.
- SEND:
  - On each fall, ps2_data_oe <= ~frame[bit_cnt] and bit_cnt increments.
  - Falls 1-8 present data bits 0-7, fall 9 presents parity, fall 10 presents stop (data released).
  - After fall 10, go to ACK.
- ACK:
  - On the next fall (11th), sample synced data.
  - If data = 0, go to WAIT_IDLE.
  - If data = 1, pulse tx_error and go to IDLE.
- WAIT_IDLE:
  - Wait until synced clock = 1 and synced data = 1.
  - Then pulse tx_done and go to IDLE; tx_ready is 1 in the same cycle as tx_done.
- Timeout:
  - The counter runs from entry to SEND through the end of WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES: both oe <= 0, tx_error pulses, go to IDLE.
  - If the timeout and a fall/ACK coincide in the same cycle, the timeout wins.
- The host never drives ps2_clk_oe outside INHIBIT. ps2_data_oe is never 1 in IDLE or WAIT_IDLE.
- tx_done and tx_error never assert together, and exactly one of them follows every accepted request unless reset intervenes.
- Parity is odd: for 0x00, parity = 1; for 0xF4, parity = 0.

Test Plan:
- Bench settings: INHIBIT_CYCLES = 20, TIMEOUT_CYCLES = 4000. The device model toggles the clock at a 40-clk half-period and pulls data low on the 11th clock low phase.
- Send 0xED -> clk_oe high for 19 cycles then released; data bits sampled by the model on rising edges = 1,0,1,1,0,1,1,1, parity 1, stop 1; ACK 0; tx_done pulses once; tx_ready returns to 1.
- Send 0xF4 with the model leaving data high at the ACK clock -> tx_error pulses once, no tx_done, both oe = 0 afterwards.
- Model never generates clocks after clock release -> tx_error pulses exactly 4000 cycles after SEND entry; lines released.
- Assert tx_valid with 0x55 while busy sending 0x00 -> 0x55 not sent; the 0x00 frame carries parity 1; exactly one tx_done.
- Assert reset_n = 0 at data bit 4 of 0xFF -> both oe = 0 in the same cycle (asynchronous); after release, tx_ready = 1 and a new 0x01 (parity 0) completes with tx_done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, start bit, 8 data bits
// LSB-first, odd parity, stop, device ACK, with a shared inhibit/timeout counter.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } stateT;

    localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    stateT            state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bitCnt;
    logic [9:0]       frame;

    logic clkMeta, clkSync, clkPrev;
    logic dataMeta, dataSync;
    logic fall;
    logic timeout;

    // Synchronizers reset to the idle (high) bus level so no spurious fall follows reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clkMeta  <= 1'b1;
            clkSync  <= 1'b1;
            clkPrev  <= 1'b1;
            dataMeta <= 1'b1;
            dataSync <= 1'b1;
        end else begin
            clkMeta  <= ps2_clk_in;
            clkSync  <= clkMeta;
            clkPrev  <= clkSync;
            dataMeta <= ps2_data_in;
            dataSync <= dataMeta;
        end
    end

    assign fall    = clkPrev & ~clkSync;
    assign timeout = (cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bitCnt      <= '0;
            frame       <= '0;
            tx_ready    <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        frame      <= {1'b1, ~^tx_data, tx_data};
                        cnt        <= '0;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == INH_PRE) begin
                        ps2_data_oe <= 1'b1;
                    end
                    if (cnt == INH_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        cnt        <= '0;
                        bitCnt     <= '0;
                        state      <= SEND;
                    end
                end

                SEND, ACK, WAIT_IDLE: begin
                    cnt <= cnt + CNT_W'(1);
                    // Timeout is checked first so it wins over a coinciding fall or ACK.
                    if (timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_error    <= 1'b1;
                        tx_ready    <= 1'b1;
                        tx_busy     <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        case (state)
                            SEND: begin
                                if (fall) begin
                                    ps2_data_oe <= ~frame[bitCnt];
                                    bitCnt      <= bitCnt + 4'd1;
                                    if (bitCnt == 4'd9) begin
                                        state <= ACK;
                                    end
                                end
                            end
                            ACK: begin
                                if (fall) begin
                                    ps2_data_oe <= 1'b0;
                                    if (!dataSync) begin
                                        state <= WAIT_IDLE;
                                    end else begin
                                        tx_error <= 1'b1;
                                        tx_ready <= 1'b1;
                                        tx_busy  <= 1'b0;
                                        state    <= IDLE;
                                    end
                                end
                            end
                            default: begin
                                if (clkSync && dataSync) begin
                                    tx_done  <= 1'b1;
                                    tx_ready <= 1'b1;
                                    tx_busy  <= 1'b0;
                                    state    <= IDLE;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_ready    <= 1'b1;
                    tx_busy     <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on the wired-AND bus plus a scoreboard
// monitor that checks every done/error pulse against queued expectations.
module tb_ps2_host_tx;

    localparam int M_NORMAL = 0;
    localparam int M_NOACK  = 1;
    localparam int M_NOCLK  = 2;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_busy, tx_done, tx_error;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;

    logic       devClk;
    logic       devData;
    int         mode;
    int         curFall;
    logic [9:0] captured;

    int tests;
    int fails;
    int doneCount;
    int errCount;

    typedef struct {
        logic       isErr;
        logic       chkFrame;
        logic [9:0] frame;
    } expT;

    expT sb[$];

    assign ps2_clk_in  = ~ps2_clk_oe & devClk;
    assign ps2_data_in = ~ps2_data_oe & devData;

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .TIMEOUT_CYCLES(4000),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_error(tx_error),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Device model: 40-clk half-period clocks, samples host data on rising edges.
    task automatic halfWait(output logic ab);
        ab = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!reset_n) begin
                ab = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic aborted;
        devClk   = 1'b1;
        devData  = 1'b1;
        curFall  = 0;
        captured = '0;
        forever begin
            @(negedge clk);
            if (reset_n && mode != M_NOCLK && !ps2_clk_oe && ps2_data_oe) begin
                captured = '0;
                aborted  = 1'b0;
                repeat (20) @(negedge clk);
                for (int i = 1; i <= 11 && !aborted; i++) begin
                    curFall = i;
                    devClk  = 1'b0;
                    if (i == 11 && mode == M_NORMAL) devData = 1'b0;
                    halfWait(aborted);
                    devClk  = 1'b1;
                    devData = 1'b1;
                    if (!aborted && i <= 10) captured[i-1] = ~ps2_data_oe;
                    if (!aborted) halfWait(aborted);
                end
                devClk  = 1'b1;
                devData = 1'b1;
                curFall = 0;
                while (!reset_n) @(negedge clk);
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (reset_n && (tx_done || tx_error)) begin
                if (tx_done) doneCount++;
                if (tx_error) errCount++;
                check("done_and_error_exclusive", {31'd0, tx_done & tx_error}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("outcome_is_error", {31'd0, tx_error}, {31'd0, e.isErr});
                    if (e.chkFrame) check("frame_bits", {22'd0, captured}, {22'd0, e.frame});
                    if (tx_done) check("ready_with_done", {30'd0, tx_ready, tx_busy}, 32'd2);
                end
            end
        end
    end

    task automatic sendCmd(input logic [7:0] d, input logic isErr, input logic chk,
                           input logic [9:0] fr, input int m);
        expT e;
        mode = m;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        e.isErr = isErr;
        e.chkFrame = chk;
        e.frame = fr;
        sb.push_back(e);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = '0;
        check("accept_busy", {30'd0, tx_ready, tx_busy}, 32'd1);
    endtask

    task automatic measureInhibit(output int lowN, output int bothN);
        lowN  = 0;
        bothN = 0;
        for (int k = 0; k < 200; k++) begin
            if (ps2_clk_oe && !ps2_data_oe) lowN++;
            else if (ps2_clk_oe && ps2_data_oe) bothN++;
            else break;
            @(negedge clk);
        end
    endtask

    task automatic waitIdle(input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge clk);
        check("response_within_budget", sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        int lowN, bothN, d0, e0, cyc;
        logic found, sawClk;
        tests = 0; fails = 0; doneCount = 0; errCount = 0;
        reset_n = 1'b0; tx_valid = 1'b0; tx_data = '0; mode = M_NORMAL;

        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_pulses", {30'd0, tx_done, tx_error}, 32'd0);
        check("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0xED with ACK
        d0 = doneCount;
        sendCmd(8'hED, 1'b0, 1'b1, 10'h3ED, M_NORMAL);
        measureInhibit(lowN, bothN);
        check("inhibit_clk_only_cycles", lowN, 32'd19);
        check("inhibit_start_overlap", bothN, 32'd1);
        check("release_start_bit", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd1);
        waitIdle(3000);
        check("ed_done_count", doneCount - d0, 32'd1);
        check("ed_idle_state", {29'd0, tx_ready, ps2_clk_oe, ps2_data_oe}, 32'd4);

        // 0xF4 without ACK
        d0 = doneCount; e0 = errCount;
        sendCmd(8'hF4, 1'b1, 1'b1, 10'h2F4, M_NOACK);
        waitIdle(3000);
        check("noack_err_count", errCount - e0, 32'd1);
        check("noack_done_count", doneCount - d0, 32'd0);
        check("noack_oe_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        repeat (100) @(negedge clk);

        // No device clocks: timeout
        e0 = errCount;
        sendCmd(8'hA5, 1'b1, 1'b0, 10'h000, M_NOCLK);
        measureInhibit(lowN, bothN);
        cyc = 0; found = 1'b0;
        while (cyc < 5000 && !found) begin
            @(negedge clk);
            cyc++;
            found = tx_error;
        end
        check("timeout_latency", cyc, 32'd4000);
        @(negedge clk);
        check("timeout_oe_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("timeout_err_count", errCount - e0, 32'd1);
        waitIdle(10);

        // 0x00 with a second request while busy
        d0 = doneCount;
        sendCmd(8'h00, 1'b0, 1'b1, 10'h300, M_NORMAL);
        repeat (200) @(negedge clk);
        tx_data = 8'h55; tx_valid = 1'b1;
        repeat (50) @(negedge clk);
        check("busy_not_ready", {31'd0, tx_ready}, 32'd0);
        repeat (50) @(negedge clk);
        tx_valid = 1'b0; tx_data = '0;
        waitIdle(3000);
        check("busy_done_count", doneCount - d0, 32'd1);
        sawClk = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ps2_clk_oe) sawClk = 1'b1;
        end
        check("busy_no_second_frame", {31'd0, sawClk}, 32'd0);
        check("busy_done_count_after", doneCount - d0, 32'd1);

        // Reset during data bit 4 of 0xFF, then 0x01
        sendCmd(8'hFF, 1'b0, 1'b1, 10'h3FF, M_NORMAL);
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            found = (curFall == 5);
        end
        check("reached_bit4", {31'd0, found}, 32'd1);
        repeat (10) @(negedge clk);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("async_reset_ready", {30'd0, tx_ready, tx_busy}, 32'd2);
        check("async_reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", {31'd0, tx_ready}, 32'd1);
        repeat (50) @(negedge clk);
        d0 = doneCount;
        sendCmd(8'h01, 1'b0, 1'b1, 10'h201, M_NORMAL);
        waitIdle(3000);
        check("post_reset_done_count", doneCount - d0, 32'd1);

        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
